// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_WIDTH-1:0] DIVZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational trial subtract a - b as a + ~b + 1 in propagate/generate form.
module div_trial_sub #(
    parameter int unsigned N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N-1:0] p;
    logic [N-1:0] g;
    logic [N:0]   c;

    // Ripple the carry through the p/g terms; a missing carry-out means a borrow.
    always_comb begin
        p    = a ^ ~b;
        g    = a & ~b;
        c    = '0;
        c[0] = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        diff   = p ^ c[N-1:0];
        borrow = ~c[N];
    end

endmodule

// File: rtl/seq_divider_32bit.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
module seq_divider_32bit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    div_state_t       state;
    div_state_t       next_state;
    logic             in_ready_d;
    logic             out_valid_d;

    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] divisor_r;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    logic             trial_neg;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] q_step;

    assign accept    = in_valid & in_ready;
    assign last_step = (counter == CW'(WIDTH - 1));

    div_trial_sub #(
        .N (WIDTH + 1)
    ) u_trial (
        .a      ({rem, q_sh[WIDTH-1]}),
        .b      ({1'b0, divisor_r}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    // Both flags mark a negative trial; they agree while rem < divisor holds.
    assign trial_neg = trial_borrow | trial_diff[WIDTH];
    assign rem_step  = trial_neg ? {rem[WIDTH-2:0], q_sh[WIDTH-1]} : trial_diff[WIDTH-1:0];
    assign q_step    = {q_sh[WIDTH-2:0], ~trial_neg};

    // State and handshake flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // Next-state logic; handshake flags follow the state being entered.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        in_ready_d  = (next_state == IDLE);
        out_valid_d = (next_state == DONE);
    end

    // Operand capture, restoring steps and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter     <= '0;
            rem         <= '0;
            q_sh        <= '0;
            divisor_r   <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            counter   <= '0;
            rem       <= '0;
            q_sh      <= dividend;
            divisor_r <= divisor;
            if (divisor == '0) begin
                quotient    <= {WIDTH{1'b1}};
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                div_by_zero <= 1'b0;
            end
        end else if (state == CALC) begin
            rem     <= rem_step;
            q_sh    <= q_step;
            counter <= counter + CW'(1);
            if (last_step) begin
                quotient  <= q_step;
                remainder <= rem_step;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider_32bit.sv
// Self-checking bench for seq_divider_32bit: directed table, reset corners, random ops.
module tb_seq_divider_32bit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider_32bit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present operands until accepted, then scramble them to prove they are ignored.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("accept_timeout", 64'(guard >= 200), 64'(0));
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Count edges after the accept edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            check("calc_in_ready", 64'(in_ready), 64'(0));
            @(posedge clk); #1;
            divisor = $urandom;
            lat++;
        end
    endtask

    // Hold out_ready low for a while, then consume the result.
    task automatic pop(input int hold, input logic [31:0] eq, input logic [31:0] er, input logic edz);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_in_ready", 64'(in_ready), 64'(0));
            check("hold_quotient", 64'(quotient), 64'(eq));
            check("hold_remainder", 64'(remainder), 64'(er));
            check("hold_dz", 64'(div_by_zero), 64'(edz));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 64'(out_valid), 64'(0));
        check("release_in_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 32, 0};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 32, 2};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 32, 1};
        vecs[3] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 0,  3};
        vecs[4] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          1'b0, 32, 0};
        vecs[5] = '{32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF,  1'b0, 32, 1};
        vecs[6] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1, 0,  0};
        vecs[7] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 32, 0};
        vecs[8] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 32, 10};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_quotient", 64'(quotient), 64'(0));
        check("reset_remainder", 64'(remainder), 64'(0));
        check("reset_dz", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table; odd entries keep out_ready high while computing.
        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            if (i % 2 == 1) out_ready = 1'b1;
            wait_result(lat);
            check("latency", 64'(lat), 64'(vecs[i].lat));
            check("quotient", 64'(quotient), 64'(vecs[i].q));
            check("remainder", 64'(remainder), 64'(vecs[i].r));
            check("div_by_zero", 64'(div_by_zero), 64'(vecs[i].dz));
            check("done_in_ready", 64'(in_ready), 64'(0));
            pop(vecs[i].hold, vecs[i].q, vecs[i].r, vecs[i].dz);
        end

        // Reset in the 10th CALC cycle aborts the operation immediately.
        start_op(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #3;
        check("calc_busy", 64'(in_ready), 64'(0));
        rst_n = 1'b0;
        #1;
        check("rst_calc_out_valid", 64'(out_valid), 64'(0));
        check("rst_calc_in_ready", 64'(in_ready), 64'(1));
        check("rst_calc_remainder", 64'(remainder), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while a divide-by-zero result is pending drops it.
        start_op(32'd5, 32'd0);
        #2;
        check("dz_pending", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst_done_out_valid", 64'(out_valid), 64'(0));
        check("rst_done_in_ready", 64'(in_ready), 64'(1));
        check("rst_done_quotient", 64'(quotient), 64'(0));
        check("rst_done_remainder", 64'(remainder), 64'(0));
        check("rst_done_dz", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        start_op(32'd1000, 32'd33);
        wait_result(lat);
        check("post_rst_latency", 64'(lat), 64'(32));
        check("post_rst_quotient", 64'(quotient), 64'(30));
        check("post_rst_remainder", 64'(remainder), 64'(10));
        check("post_rst_dz", 64'(div_by_zero), 64'(0));
        pop(1, 32'd30, 32'd10, 1'b0);

        // Random operands against plain / and % with random backpressure.
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = a + 32'($urandom_range(0, 3));
                3:       b = 32'($urandom) >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if (b == 32'd0) begin
                eq  = 32'hFFFF_FFFF;
                er  = a;
                edz = 1'b1;
            end else begin
                eq  = a / b;
                er  = a % b;
                edz = 1'b0;
            end
            start_op(a, b);
            wait_result(lat);
            check("rnd_latency", 64'(lat), 64'(edz ? 0 : 32));
            check("rnd_quotient", 64'(quotient), 64'(eq));
            check("rnd_remainder", 64'(remainder), 64'(er));
            check("rnd_dz", 64'(div_by_zero), 64'(edz));
            pop($urandom_range(0, 3), eq, er, edz);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
